traffic_conflict_monitor: RTL and testbench
===========================================

Name: traffic_conflict_monitor

Overview:
Safety stage directly downstream of traffic_light. It consumes the six lamp signals (two approaches × R/Y/G) and normally passes them through registered to the lamp drivers. It checks every cycle for unsafe or illegal patterns. On a confirmed fault it latches into a fail-safe flashing-yellow mode that only reset clears.

Parameters:
- FLASH_HALF_CYCLES, 8000000: cycles per flash half-period (0.5 s at 16 MHz).
- FAULT_FILTER_CYCLES, 2: consecutive cycles a level fault (conflict or illegal head) must persist before latching; legal range ≥1.
- MIN_YELLOW_CYCLES, 48000000: minimum legal yellow duration per head (3 s at 16 MHz).

Ports:
- clk  in  1  system clock, 16 MHz
- rst  in  1  reset, asynchronous, active-high
- in_red1, in_yellow1, in_green1  in  1 each  approach 1 lamps from traffic_light
- in_red2, in_yellow2, in_green2  in  1 each  approach 2 lamps from traffic_light
- lamp_red1, lamp_yellow1, lamp_green1  out  1 each  approach 1 lamp drive
- lamp_red2, lamp_yellow2, lamp_green2  out  1 each  approach 2 lamp drive
- fault  out  1  high while in FLASH
- fault_code  out  2  first latched cause: 0 none, 1 conflict, 2 illegal head, 3 short yellow

Behaviour:
- Clocking and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values:
  - lamp_red1 = lamp_red2 = 1; all yellow and green outputs 0 (all-red).
  - fault = 0, fault_code = 0, state NORMAL.
  - All counters 0.
  - Input registers (in_q) load all-red.
- Input stage: all six inputs are registered into in_q every cycle. All checks use in_q only.
- States:
  - NORMAL → FLASH on a latched fault.
  - FLASH is absorbing; only rst exits it.
- Fault conditions, evaluated each cycle on in_q:
  - Illegal head (code 2): for either head, the number of active lamps is ≠ 1 (zero or two or more).
  - Conflict (code 1): red1 = 0 and red2 = 0 simultaneously.
  - Short yellow (code 3): a head's yellow falls 1→0 in in_q while that head's yellow run count < MIN_YELLOW_CYCLES.
- Yellow run counters:
  - One per head; counts cycles with in_q yellow = 1.
  - Saturates at MIN_YELLOW_CYCLES.
  - Cleared on the cycle after the falling edge.
- Priority when several conditions hold in the same cycle: 2 > 1 > 3.
- Level-fault filter:
  - A shared counter increments on each edge where code 1 or 2 is present, and clears on any edge where neither is present.
  - On the edge the counter reaches FAULT_FILTER_CYCLES: enter FLASH and latch fault_code using the priority above, evaluated at that edge.
- Short yellow is an event, not filtered: enter FLASH on the same edge the falling edge is seen.
- Lamp outputs in NORMAL:
  - When no level condition is present, lamp_* ← in_q. Pass-through latency is 2 clk from input to output.
  - While a level condition is present but not yet latched, lamp_* hold their last value, so a bad pattern never reaches the lamps.
- Lamp outputs in FLASH:
  - All red and green outputs are 0.
  - lamp_yellow1 = lamp_yellow2 = flash phase.
  - Phase is 1 for the first FLASH_HALF_CYCLES cycles after entry, then toggles every FLASH_HALF_CYCLES cycles.
  - fault = 1. fault_code is held; later faults do not overwrite it.
- Counter widths: $clog2(param+1). There is no wrap-around: flash counter reloads on toggle, yellow counters saturate.
- Reset asserted mid-operation (including mid-flash): outputs go to reset values immediately (async). Monitoring restarts from all-red.

Test Plan:
Bench overrides: FLASH_HALF_CYCLES=4, FAULT_FILTER_CYCLES=2, MIN_YELLOW_CYCLES=5.
1. Normal pass-through: drive the legal sequence R1/G2 30 cyc → R1/Y2 5 cyc → R1/R2 2 cyc → G1/R2. Outputs must equal inputs delayed 2 clk, with fault = 0 throughout.
2. Conflict: from R1/G2, drive G1/G2 for 2 cycles. Required:
   - Lamps hold R1/G2 during the pending cycles.
   - FLASH with fault = 1, fault_code = 1.
   - Yellows toggle high 4 / low 4 repeatedly; reds and greens stay 0.
3. Glitch rejection: drive G1/G2 for 1 cycle, then R1/G2. Required: fault stays 0, and lamps return to R1/G2 pass-through with no conflict visible.
4. Illegal head and priority:
   - Drive all-zero on head 1 for 2 cycles → fault_code = 2.
   - After reset, drive head 1 = G+Y with head 2 green → fault_code = 2, not 1.
5. Yellow timing:
   - Yellow2 for exactly 5 cycles then red → no fault.
   - Yellow2 for 4 cycles then red → FLASH, fault_code = 3, on the edge the falling edge is sampled.
6. Reset mid-flash: assert rst asynchronously between clock edges while flashing. Required: lamps go to R1=R2=1, fault = 0, fault_code = 0 immediately; legal input after release passes through.

Source files
------------

// File: rtl/traffic_conflict_monitor.sv
// Safety stage behind traffic_light: registers the six lamp requests, screens them for conflicting,
// illegal or short-yellow patterns, and latches into flashing yellow on a confirmed fault.
module traffic_conflict_monitor #(
  parameter int unsigned FLASH_HALF_CYCLES   = 8000000,
  parameter int unsigned FAULT_FILTER_CYCLES = 2,
  parameter int unsigned MIN_YELLOW_CYCLES   = 48000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_red1,
  input  logic       in_yellow1,
  input  logic       in_green1,
  input  logic       in_red2,
  input  logic       in_yellow2,
  input  logic       in_green2,
  output logic       lamp_red1,
  output logic       lamp_yellow1,
  output logic       lamp_green1,
  output logic       lamp_red2,
  output logic       lamp_yellow2,
  output logic       lamp_green2,
  output logic       fault,
  output logic [1:0] fault_code
);

  localparam int unsigned FW = $clog2(FLASH_HALF_CYCLES + 1);
  localparam int unsigned TW = $clog2(FAULT_FILTER_CYCLES + 1);
  localparam int unsigned YW = $clog2(MIN_YELLOW_CYCLES + 1);

  localparam logic [FW-1:0] FlashLast = FW'(FLASH_HALF_CYCLES - 1);
  localparam logic [TW-1:0] FiltMax   = TW'(FAULT_FILTER_CYCLES);
  localparam logic [TW-1:0] FiltLast  = TW'(FAULT_FILTER_CYCLES - 1);
  localparam logic [YW-1:0] YelMin    = YW'(MIN_YELLOW_CYCLES);

  // Lamp vector order: {red1, yellow1, green1, red2, yellow2, green2}
  localparam logic [5:0] AllRed = 6'b100_100;

  localparam logic [1:0] CodeConflict = 2'd1;
  localparam logic [1:0] CodeIllegal  = 2'd2;
  localparam logic [1:0] CodeShortYel = 2'd3;

  typedef enum logic {StNormal, StFlash} state_e;

  state_e          state_q, state_d;
  logic [5:0]      in_q, lamp_q, lamp_d;
  logic [1:0]      code_q, code_d;
  logic            phase_q, phase_d;
  logic [FW-1:0]   fcnt_q, fcnt_d;
  logic [TW-1:0]   filt_q, filt_d;
  logic [YW-1:0]   ycnt1_q, ycnt1_d, ycnt2_q, ycnt2_d;

  logic illegal, conflict, level, short_yel, level_latch, trip;
  logic [1:0] code_now;

  always_comb begin
    illegal  = !$onehot(in_q[5:3]) || !$onehot(in_q[2:0]);
    conflict = !in_q[5] && !in_q[2];
    level    = illegal || conflict;

    // A non-zero run count means yellow was on last cycle, so yellow low now is a falling edge.
    short_yel = (!in_q[4] && (ycnt1_q != '0) && (ycnt1_q < YelMin)) ||
                (!in_q[1] && (ycnt2_q != '0) && (ycnt2_q < YelMin));

    ycnt1_d = !in_q[4] ? '0 : (ycnt1_q == YelMin) ? YelMin : ycnt1_q + 1'b1;
    ycnt2_d = !in_q[1] ? '0 : (ycnt2_q == YelMin) ? YelMin : ycnt2_q + 1'b1;

    filt_d      = !level ? '0 : (filt_q == FiltMax) ? FiltMax : filt_q + 1'b1;
    level_latch = level && (filt_q >= FiltLast);
    trip        = level_latch || short_yel;

    code_now = illegal ? CodeIllegal : conflict ? CodeConflict : CodeShortYel;
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    lamp_d  = lamp_q;
    phase_d = phase_q;
    fcnt_d  = fcnt_q;
    unique case (state_q)
      StNormal: begin
        if (trip) begin
          state_d = StFlash;
          code_d  = code_now;
          phase_d = 1'b1;
          fcnt_d  = '0;
        end else if (!level) begin
          // Pending level faults freeze the lamps so a bad pattern never reaches them.
          lamp_d = in_q;
        end
      end
      StFlash: begin
        if (fcnt_q == FlashLast) begin
          fcnt_d  = '0;
          phase_d = !phase_q;
        end else begin
          fcnt_d = fcnt_q + 1'b1;
        end
      end
      default: state_d = StNormal;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StNormal;
      in_q    <= AllRed;
      lamp_q  <= AllRed;
      code_q  <= '0;
      phase_q <= 1'b0;
      fcnt_q  <= '0;
      filt_q  <= '0;
      ycnt1_q <= '0;
      ycnt2_q <= '0;
    end else begin
      state_q <= state_d;
      in_q    <= {in_red1, in_yellow1, in_green1, in_red2, in_yellow2, in_green2};
      lamp_q  <= lamp_d;
      code_q  <= code_d;
      phase_q <= phase_d;
      fcnt_q  <= fcnt_d;
      filt_q  <= filt_d;
      ycnt1_q <= ycnt1_d;
      ycnt2_q <= ycnt2_d;
    end
  end

  always_comb begin
    fault        = (state_q == StFlash);
    fault_code   = code_q;
    lamp_red1    = !fault && lamp_q[5];
    lamp_yellow1 = fault ? phase_q : lamp_q[4];
    lamp_green1  = !fault && lamp_q[3];
    lamp_red2    = !fault && lamp_q[2];
    lamp_yellow2 = fault ? phase_q : lamp_q[1];
    lamp_green2  = !fault && lamp_q[0];
  end

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Scoreboarded directed bench for traffic_conflict_monitor with short timing parameters.
module tb_traffic_conflict_monitor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] drv = 6'b100_100;
  logic lamp_red1, lamp_yellow1, lamp_green1, lamp_red2, lamp_yellow2, lamp_green2;
  logic fault;
  logic [1:0] fault_code;

  always #5 clk = ~clk;

  traffic_conflict_monitor #(
    .FLASH_HALF_CYCLES  (4),
    .FAULT_FILTER_CYCLES(2),
    .MIN_YELLOW_CYCLES  (5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_red1     (drv[5]),
    .in_yellow1  (drv[4]),
    .in_green1   (drv[3]),
    .in_red2     (drv[2]),
    .in_yellow2  (drv[1]),
    .in_green2   (drv[0]),
    .lamp_red1   (lamp_red1),
    .lamp_yellow1(lamp_yellow1),
    .lamp_green1 (lamp_green1),
    .lamp_red2   (lamp_red2),
    .lamp_yellow2(lamp_yellow2),
    .lamp_green2 (lamp_green2),
    .fault       (fault),
    .fault_code  (fault_code)
  );

  // {red1, yellow1, green1, red2, yellow2, green2}
  localparam logic [5:0] R1R2  = 6'b100_100;
  localparam logic [5:0] R1G2  = 6'b100_001;
  localparam logic [5:0] R1Y2  = 6'b100_010;
  localparam logic [5:0] G1R2  = 6'b001_100;
  localparam logic [5:0] G1G2  = 6'b001_001;
  localparam logic [5:0] Z1G2  = 6'b000_001;
  localparam logic [5:0] GY1G2 = 6'b011_001;
  localparam logic [5:0] FON   = 6'b010_010;
  localparam logic [5:0] FOFF  = 6'b000_000;

  typedef struct packed {
    logic [5:0] lamps;
    logic       flt;
    logic [1:0] code;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  string tag = "init";

  function automatic logic [5:0] obs_lamps();
    return {lamp_red1, lamp_yellow1, lamp_green1, lamp_red2, lamp_yellow2, lamp_green2};
  endfunction

  task automatic check(input string name, input exp_t e);
    exp_t a;
    a = '{lamps: obs_lamps(), flt: fault, code: fault_code};
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s @%0t: got lamps=%b fault=%b code=%0d, want lamps=%b fault=%b code=%0d",
               name, $time, a.lamps, a.flt, a.code, e.lamps, e.flt, e.code);
    end
  endtask

  // Monitor: every edge with a queued expectation is compared just after the edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) check(tag, exp_q.pop_front());
  end

  // Drive one input pattern for n cycles; e is the response expected after each of those edges.
  task automatic vec(input logic [5:0] in, input logic [5:0] lamps, input logic flt,
                     input logic [1:0] code, input int n);
    repeat (n) begin
      @(negedge clk);
      drv = in;
      exp_q.push_back('{lamps: lamps, flt: flt, code: code});
    end
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check({name, "_async_rst"}, '{lamps: R1R2, flt: 1'b0, code: 2'd0});
    drv = R1R2;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_state", '{lamps: R1R2, flt: 1'b0, code: 2'd0});
    rst = 1'b0;

    // Legal cycle; yellow of exactly 5 cycles must not fault.
    tag = "pass_through";
    vec(R1G2, R1R2, 0, 0, 1);
    vec(R1G2, R1G2, 0, 0, 29);
    vec(R1Y2, R1G2, 0, 0, 1);
    vec(R1Y2, R1Y2, 0, 0, 4);
    vec(R1R2, R1Y2, 0, 0, 1);
    vec(R1R2, R1R2, 0, 0, 1);
    vec(G1R2, R1R2, 0, 0, 1);
    vec(G1R2, G1R2, 0, 0, 5);

    // Single-cycle conflict is filtered out.
    do_reset("glitch");
    tag = "glitch";
    vec(R1G2, R1R2, 0, 0, 1);
    vec(R1G2, R1G2, 0, 0, 2);
    vec(G1G2, R1G2, 0, 0, 1);
    vec(R1G2, R1G2, 0, 0, 4);

    // Two-cycle conflict latches code 1 and flashes 4 on / 4 off.
    tag = "conflict";
    vec(G1G2, R1G2, 0, 0, 2);
    vec(R1G2, FON, 1, 1, 4);
    vec(R1G2, FOFF, 1, 1, 4);
    vec(R1Y2, FON, 1, 1, 4);
    vec(R1R2, FOFF, 1, 1, 4);
    vec(R1G2, FON, 1, 1, 2);

    // Reset mid-flash, then legal pass-through resumes from all-red.
    do_reset("midflash");
    tag = "after_reset";
    vec(G1R2, R1R2, 0, 0, 1);
    vec(G1R2, G1R2, 0, 0, 3);

    // Dark head 1 for two cycles.
    do_reset("illegal_dark");
    tag = "illegal_dark";
    vec(R1G2, R1R2, 0, 0, 1);
    vec(R1G2, R1G2, 0, 0, 1);
    vec(Z1G2, R1G2, 0, 0, 2);
    vec(R1G2, FON, 1, 2, 3);

    // G+Y on head 1 with head 2 green: illegal outranks conflict.
    do_reset("priority");
    tag = "priority";
    vec(GY1G2, R1R2, 0, 0, 2);
    vec(R1G2, FON, 1, 2, 4);
    vec(R1G2, FOFF, 1, 2, 1);

    // Four-cycle yellow: fault on the edge the fall is seen in the input register.
    do_reset("short_yellow");
    tag = "short_yellow";
    vec(R1G2, R1R2, 0, 0, 1);
    vec(R1G2, R1G2, 0, 0, 1);
    vec(R1Y2, R1G2, 0, 0, 1);
    vec(R1Y2, R1Y2, 0, 0, 3);
    vec(R1R2, R1Y2, 0, 0, 1);
    vec(R1R2, FON, 1, 3, 4);
    vec(G1G2, FOFF, 1, 3, 4);
    vec(G1R2, FON, 1, 3, 1);

    begin
      int budget;
      budget = 20;
      while (exp_q.size() > 0 && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      if (exp_q.size() > 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
